alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one 8-bit ALU instance among NREQ requesters. Round-robin arbiter
//  plus 3-state sequencer: accepts one operation, drives the ALU operand/select
//  bus for one cycle, and returns the captured result tagged with the requester
//  ID. Sits between request sources (decoders, DMA, test ports) and the ALU.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  ID_W  2  requester ID width, must satisfy 2**ID_W >= NREQ
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous reset, active-high
//  req_valid    in   NREQ     per-requester operation valid
//  req_ready    out  NREQ     one-hot accept; req i taken when valid[i]&ready[i]
//  req_a        in   NREQ*8   operand A, requester i at [8i+7:8i]
//  req_b        in   NREQ*8   operand B, same packing
//  req_sel      in   NREQ*4   ALU select, requester i at [4i+3:4i]
//  alu_a        out  8        operand A to ALU
//  alu_b        out  8        operand B to ALU
//  alu_sel      out  4        select to ALU
//  alu_res      in   8        ALU result (combinational from alu_a/b/sel)
//  alu_carry    in   1        ALU carry (valid for add only)
//  rsp_valid    out  1        response valid
//  rsp_ready    in   1        response consumer ready
//  rsp_id       out  ID_W     requester index of this response
//  rsp_res      out  8        captured result
//  rsp_carry    out  1        captured carry
//  rsp_err      out  1        1 when captured sel > 4'b1001 (undefined op)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; req_ready=0; rsp_valid=0; rsp_id, rsp_res,
//   rsp_carry, rsp_err=0; alu_a/alu_b/alu_sel=0; rr pointer=NREQ-1.
//  States: IDLE -> EXEC -> RESP -> IDLE. One operation in flight, no overlap.
//  IDLE: if any req_valid, grant winner combinationally: first valid index
//   searching from (ptr+1) mod NREQ upward with wrap. req_ready[winner]=1 this
//   cycle only; all others 0. On the edge: latch A/B/sel/ID, ptr<=winner,
//   go EXEC. No valid -> stay IDLE, req_ready=0.
//  req_ready is 0 in EXEC and RESP for all requesters.
//  EXEC (one cycle): alu_a/b/sel driven from latched registers (registered
//   outputs, stable whole cycle). Edge: rsp_res<=alu_res, rsp_carry<=alu_carry,
//   rsp_err<=(sel>9), rsp_id<=latched ID, rsp_valid<=1, go RESP.
//  RESP: hold rsp_* stable while rsp_valid=1 & rsp_ready=0. On rsp_valid &
//   rsp_ready: rsp_valid<=0, go IDLE. rsp_ready ignored when rsp_valid=0.
//  Latency: accept edge N -> rsp_valid high from cycle N+2. Min throughput one
//   op per 3 cycles (accept, exec, resp-handshake).
//  alu_a/b/sel retain last values outside EXEC (no toggling when idle).
//  Carry passed through unmodified; for non-add ops ALU drives 0.
//  Requester deasserting req_valid without handshake: legal, no effect.
//  Payload sampled only on the accept edge; later changes ignored.
//  Reset mid-operation: in-flight op discarded, no response emitted, ptr reset.
//  Invalid ptr impossible; ID values >= NREQ never produced.
// TESTING
//  1. Req0 A=8'hF0 B=8'h20 sel=0 -> rsp after 2 cycles: res=8'h10 carry=1 id=0 err=0.
//  2. All 4 valid from reset, rsp_ready=1 -> grants in order 0,1,2,3, one every
//     3 cycles; sel=1 A=8'h05 B=8'h07 gives res=8'hFE carry=0.
//  3. Fairness: after grant to 2, reqs 0,2,3 valid -> next grants 3,0,2.
//  4. Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready all 0,
//     no new accept until handshake.
//  5. Req1 sel=4'b1111 A=8'hAA -> res=8'h00 err=1 id=1; sel=4'b1000 A=8'h81 -> res=8'h03.
//  6. Assert rst during EXEC -> next cycle rsp_valid=0, state IDLE, pending
//     req0 re-granted first after rst release.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter and three-state sequencer sharing one 8-bit ALU among NREQ requesters.
// One operation is in flight at a time; the result returns tagged with the requester index.
module alu_rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned ID_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_a,
   input  logic [NREQ*8-1:0] req_b,
   input  logic [NREQ*4-1:0] req_sel,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [3:0]        alu_sel,
   input  logic [7:0]        alu_res,
   input  logic              alu_carry,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ID_W-1:0]   rsp_id,
   output logic [7:0]        rsp_res,
   output logic              rsp_carry,
   output logic              rsp_err
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e          state_q;
   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] id_q;

   logic [NREQ-1:0] upper;
   logic [NREQ-1:0] cand;
   logic [NREQ-1:0] gnt;
   logic            gnt_any;
   logic [ID_W-1:0] gnt_id;
   logic [7:0]      gnt_a;
   logic [7:0]      gnt_b;
   logic [3:0]      gnt_sel;

   // Requesters above the pointer take priority; if none are valid, wrap to the lowest valid.
   always_comb begin
      upper = '0;
      for (int i = 0; i < NREQ; i++) begin
         upper[i] = req_valid[i] && (ID_W'(i) > ptr_q);
      end
      cand = (|upper) ? upper : req_valid;

      gnt     = '0;
      gnt_any = 1'b0;
      gnt_id  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!gnt_any && cand[i]) begin
            gnt_any = 1'b1;
            gnt_id  = ID_W'(i);
            gnt[i]  = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_a   = '0;
      gnt_b   = '0;
      gnt_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gnt_a   = req_a[8*i +: 8];
            gnt_b   = req_b[8*i +: 8];
            gnt_sel = req_sel[4*i +: 4];
         end
      end
   end

   // Held at zero during reset so no requester sees an accept it could act on.
   assign req_ready = (state_q == StIdle && !rst) ? gnt : '0;

   // The ALU operand registers double as the payload latch, so they already hold the
   // accepted operation for the whole EXEC cycle and keep it afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         ptr_q     <= ID_W'(NREQ - 1);
         id_q      <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_res   <= '0;
         rsp_carry <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (gnt_any) begin
                  alu_a   <= gnt_a;
                  alu_b   <= gnt_b;
                  alu_sel <= gnt_sel;
                  id_q    <= gnt_id;
                  ptr_q   <= gnt_id;
                  state_q <= StExec;
               end
            end
            StExec: begin
               rsp_res   <= alu_res;
               rsp_carry <= alu_carry;
               rsp_err   <= (alu_sel > 4'd9);
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state_q   <= StResp;
            end
            StResp: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   a_ready_idle:   assert property (@(posedge clk) disable iff (rst)
                                    (state_q != StIdle) |-> (req_ready == '0));
   a_rsp_hold:     assert property (@(posedge clk) disable iff (rst)
                                    (rsp_valid && !rsp_ready) |=>
                                    (rsp_valid && $stable({rsp_id, rsp_res, rsp_carry, rsp_err})));
   a_id_range:     assert property (@(posedge clk) disable iff (rst)
                                    rsp_valid |-> (32'(rsp_id) < NREQ));

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin / ALU reference model.
module tb_alu_rr_arbiter;

   localparam int NREQ = 4;
   localparam int ID_W = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*8-1:0] req_a;
   logic [NREQ*8-1:0] req_b;
   logic [NREQ*4-1:0] req_sel;
   logic [7:0]        alu_a;
   logic [7:0]        alu_b;
   logic [3:0]        alu_sel;
   logic [7:0]        alu_res;
   logic              alu_carry;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [7:0]        rsp_res;
   logic              rsp_carry;
   logic              rsp_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int m_ptr = NREQ - 1;

   // Observations captured by xact for the calling test to compare.
   logic [3:0] o_g;
   int         o_gcyc;
   logic [7:0] o_ea, o_eb, o_rres;
   logic [3:0] o_esel;
   logic       o_ev, o_rv, o_rc, o_re, o_hold;
   logic [1:0] o_rid;

   alu_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_res(alu_res), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_res(rsp_res), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Returns {err, carry, res[7:0]}.
   function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
      logic [8:0] t;
      case (s)
         4'd0: t = {1'b0, a} + {1'b0, b};
         4'd1: t = {1'b0, a - b};
         4'd2: t = {1'b0, a & b};
         4'd3: t = {1'b0, a | b};
         4'd4: t = {1'b0, a ^ b};
         4'd5: t = {1'b0, ~a};
         4'd6: t = {1'b0, a << 1};
         4'd7: t = {1'b0, a >> 1};
         4'd8: t = {1'b0, a[6:0], a[7]};
         4'd9: t = {1'b0, a[0], a[7:1]};
         default: t = 9'd0;
      endcase
      return {(s > 4'd9), (s == 4'd0) ? t[8] : 1'b0, t[7:0]};
   endfunction

   logic [9:0] alu_t;
   always_comb begin
      alu_t     = alu_ref(alu_a, alu_b, alu_sel);
      alu_res   = alu_t[7:0];
      alu_carry = alu_t[8];
   end

   function automatic int rr_pick(input logic [3:0] mask, input int p);
      for (int k = 1; k <= NREQ; k++) begin
         if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic do_reset;
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_ptr = NREQ - 1;
   endtask

   // Runs one operation starting at a negedge with the DUT idle; records what it sees.
   task automatic xact(input logic [3:0] mask, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] sel, input int stall);
      o_ea = 'x; o_eb = 'x; o_esel = 'x; o_ev = 'x; o_rv = 'x; o_rid = 'x;
      o_rres = 'x; o_rc = 'x; o_re = 'x; o_hold = 1'b1;
      req_valid = mask; req_a = a; req_b = b; req_sel = sel;
      #1;
      o_g = req_ready; o_gcyc = cyc;
      @(negedge clk);
      if (o_g == '0) begin
         req_valid = '0;
         return;
      end
      req_a = $urandom; req_b = $urandom; req_sel = 16'($urandom);
      o_ea = alu_a; o_eb = alu_b; o_esel = alu_sel; o_ev = rsp_valid;
      if (req_ready !== '0) o_hold = 1'b0;
      @(negedge clk);
      o_rv = rsp_valid; o_rid = rsp_id; o_rres = rsp_res; o_rc = rsp_carry; o_re = rsp_err;
      if (req_ready !== '0) o_hold = 1'b0;
      rsp_ready = 1'b0;
      repeat (stall) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_id !== o_rid || rsp_res !== o_rres ||
             rsp_carry !== o_rc || rsp_err !== o_re || req_ready !== '0 ||
             alu_a !== o_ea) o_hold = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'($urandom);
      req_valid = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
      req_a = '1; req_b = '1; req_sel = '1;
      @(negedge clk); #1;
      total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      total++; if ({rsp_id, rsp_res, rsp_carry, rsp_err} !== '0) begin bad++; $display("FAIL reset_rsp got=%h/%h/%b/%b want=0", rsp_id, rsp_res, rsp_carry, rsp_err); end
      total++; if ({alu_a, alu_b, alu_sel} !== '0) begin bad++; $display("FAIL reset_alu got=%h/%h/%h want=0", alu_a, alu_b, alu_sel); end
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0; rsp_ready = 1'b0;
      @(negedge clk); #1;
      total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL idle_no_valid got=%b want=0000", req_ready); end
      @(negedge clk);
   endtask

   task automatic test_add_carry;
      do_reset();
      xact(4'b0001, 32'h0000_00F0, 32'h0000_0020, 16'h0000, 0);
      total++; if (o_g !== 4'b0001) begin bad++; $display("FAIL add_grant got=%b want=0001", o_g); end
      total++; if ({o_ea, o_eb, o_esel} !== {8'hF0, 8'h20, 4'h0}) begin bad++; $display("FAIL add_alu_bus got=%h/%h/%h want=f0/20/0", o_ea, o_eb, o_esel); end
      total++; if (o_ev !== 1'b0) begin bad++; $display("FAIL add_early_rsp got=%b want=0", o_ev); end
      total++; if ({o_rv, o_rid, o_rres, o_rc, o_re} !== {1'b1, 2'd0, 8'h10, 1'b1, 1'b0}) begin bad++; $display("FAIL add_rsp got=v%b id%0d res%h c%b e%b want=v1 id0 res10 c1 e0", o_rv, o_rid, o_rres, o_rc, o_re); end
   endtask

   task automatic test_all_valid;
      int prev;
      do_reset();
      prev = 0;
      for (int i = 0; i < NREQ; i++) begin
         xact(4'b1111, 32'h0505_0505, 32'h0707_0707, 16'h1111, 0);
         total++; if (o_g !== 4'(1 << i)) begin bad++; $display("FAIL all_grant%0d got=%b want=%b", i, o_g, 4'(1 << i)); end
         total++; if ({o_rid, o_rres, o_rc, o_re} !== {2'(i), 8'hFE, 1'b0, 1'b0}) begin bad++; $display("FAIL all_rsp%0d got=id%0d res%h c%b e%b want=id%0d resfe c0 e0", i, o_rid, o_rres, o_rc, o_re, i); end
         if (i > 0) begin
            total++; if (o_gcyc - prev !== 3) begin bad++; $display("FAIL all_gap%0d got=%0d want=3", i, o_gcyc - prev); end
         end
         prev = o_gcyc;
      end
   endtask

   task automatic test_fairness;
      int exp_ids[3] = '{3, 0, 2};
      do_reset();
      xact(4'b0100, 32'h0, 32'h0, 16'h0, 0);
      total++; if (o_g !== 4'b0100) begin bad++; $display("FAIL fair_first got=%b want=0100", o_g); end
      foreach (exp_ids[k]) begin
         xact(4'b1101, 32'h1234_5678, 32'h1111_1111, 16'h2222, 0);
         total++; if (o_g !== 4'(1 << exp_ids[k])) begin bad++; $display("FAIL fair_grant%0d got=%b want=%b", k, o_g, 4'(1 << exp_ids[k])); end
      end
   endtask

   task automatic test_backpressure;
      int first;
      do_reset();
      xact(4'b1011, 32'h0000_0033, 32'h0000_0044, 16'h0004, 5);
      first = o_gcyc;
      total++; if (o_hold !== 1'b1) begin bad++; $display("FAIL bp_hold got=%b want=1", o_hold); end
      total++; if ({o_rv, o_rid, o_rres} !== {1'b1, 2'd0, 8'h77}) begin bad++; $display("FAIL bp_rsp got=v%b id%0d res%h want=v1 id0 res77", o_rv, o_rid, o_rres); end
      xact(4'b1011, 32'h0, 32'h0, 16'h0, 0);
      total++; if (o_g !== 4'b0010) begin bad++; $display("FAIL bp_next_grant got=%b want=0010", o_g); end
      total++; if (o_gcyc - first !== 8) begin bad++; $display("FAIL bp_gap got=%0d want=8", o_gcyc - first); end
   endtask

   task automatic test_undefined_op;
      do_reset();
      xact(4'b0010, 32'h0000_AA00, 32'h0000_5500, 16'h00F0, 1);
      total++; if ({o_rid, o_rres, o_rc, o_re} !== {2'd1, 8'h00, 1'b0, 1'b1}) begin bad++; $display("FAIL undef_rsp got=id%0d res%h c%b e%b want=id1 res00 c0 e1", o_rid, o_rres, o_rc, o_re); end
      xact(4'b0010, 32'h0000_8100, 32'h0000_0000, 16'h0080, 0);
      total++; if ({o_rid, o_rres, o_rc, o_re} !== {2'd1, 8'h03, 1'b0, 1'b0}) begin bad++; $display("FAIL rol_rsp got=id%0d res%h c%b e%b want=id1 res03 c0 e0", o_rid, o_rres, o_rc, o_re); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      req_valid = 4'b0101; req_a = 32'h0000_0011; req_b = 32'h0000_0022; req_sel = 16'h0000;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_grant got=%b want=0001", req_ready); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if ({rsp_valid, req_ready, alu_a} !== {1'b0, 4'b0000, 8'h00}) begin bad++; $display("FAIL rmid_cleared got=v%b r%b a%h want=v0 r0000 a00", rsp_valid, req_ready, alu_a); end
      @(negedge clk);
      rst = 1'b0;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_rsp got=%b want=0", rsp_valid); end
      xact(4'b0101, 32'h0033_0011, 32'h0044_0022, 16'h0000, 0);
      total++; if (o_g !== 4'b0001) begin bad++; $display("FAIL rmid_regrant got=%b want=0001", o_g); end
      total++; if ({o_rid, o_rres} !== {2'd0, 8'h33}) begin bad++; $display("FAIL rmid_rsp got=id%0d res%h want=id0 res33", o_rid, o_rres); end
   endtask

   task automatic test_random(input int n);
      logic [3:0]  mask;
      logic [31:0] a, b;
      logic [15:0] sel;
      logic [7:0]  ea, eb;
      logic [3:0]  es;
      logic [9:0]  r;
      int          w;
      do_reset();
      for (int it = 0; it < n; it++) begin
         mask = 4'($urandom);
         a = $urandom; b = $urandom; sel = 16'($urandom);
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rnd_idle%0d got=%b want=0", it, rsp_valid); end
         w = rr_pick(mask, m_ptr);
         xact(mask, a, b, sel, int'($urandom_range(0, 3)));
         if (w < 0) begin
            total++; if (o_g !== 4'b0000) begin bad++; $display("FAIL rnd_nogrant%0d got=%b want=0000", it, o_g); end
         end else begin
            ea = 8'(a >> (8 * w)); eb = 8'(b >> (8 * w)); es = 4'(sel >> (4 * w));
            r = alu_ref(ea, eb, es);
            m_ptr = w;
            total++; if (o_g !== 4'(1 << w)) begin bad++; $display("FAIL rnd_grant%0d got=%b want=%b", it, o_g, 4'(1 << w)); end
            total++; if ({o_ea, o_eb, o_esel} !== {ea, eb, es}) begin bad++; $display("FAIL rnd_alu%0d got=%h/%h/%h want=%h/%h/%h", it, o_ea, o_eb, o_esel, ea, eb, es); end
            total++; if ({o_ev, o_rv} !== 2'b01) begin bad++; $display("FAIL rnd_valid%0d got=%b%b want=01", it, o_ev, o_rv); end
            total++; if ({o_rid, o_re, o_rc, o_rres} !== {2'(w), r}) begin bad++; $display("FAIL rnd_rsp%0d got=id%0d e%b c%b res%h want=id%0d e%b c%b res%h", it, o_rid, o_re, o_rc, o_rres, w, r[9], r[8], r[7:0]); end
            total++; if (o_hold !== 1'b1) begin bad++; $display("FAIL rnd_hold%0d got=%b want=1", it, o_hold); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_sel = '0;
      test_reset();
      test_add_carry();
      test_all_valid();
      test_fairness();
      test_backpressure();
      test_undefined_op();
      test_reset_mid();
      test_random(200);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
